// File: rtl/run_supervisor.sv
// End-of-run supervisor: tracks per-core halts, errors and a cycle watchdog, and latches done/status.
// Define RUN_SUP_STALL_EN to add core_commit, STALL_LIMIT and a per-core commit-stall detector.

module run_supervisor_core #(
   parameter int NUM_LANES = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 track,
   input  logic [NUM_LANES-1:0] halt,
   output logic                 seen,
   output logic                 seen_next
);
   assign seen_next = seen | (|halt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     seen <= 1'b0;
      else if (clear) seen <= 1'b0;
      else if (track) seen <= seen_next;
   end
endmodule

`ifdef RUN_SUP_STALL_EN
module run_supervisor_stall #(
   parameter int STALL_LIMIT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   input  logic commit,
   input  logic seen_next,
   input  logic mask_bit,
   output logic stall_hit
);
   localparam int CW = $clog2(STALL_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);

   logic [CW-1:0] cnt_q, cnt_nx;

   // Halted or unmasked cores are never considered stalled.
   always_comb begin
      cnt_nx = cnt_q;
      if (commit || seen_next || !mask_bit) cnt_nx = '0;
      else if (cnt_q != LIMIT)              cnt_nx = cnt_q + CW'(1);
   end

   assign stall_hit = run && (cnt_nx == LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     cnt_q <= '0;
      else if (clear) cnt_q <= '0;
      else if (run)   cnt_q <= cnt_nx;
   end
endmodule
`endif

module run_supervisor #(
   parameter int NUM_CORES    = 2,
   parameter int NUM_LANES    = 8,
   parameter int TIMEOUT_W    = 32,
   parameter int DRAIN_CYCLES = 5
`ifdef RUN_SUP_STALL_EN
   ,parameter int STALL_LIMIT = 1024
`endif
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [TIMEOUT_W-1:0]           timeout_cycles,
   input  logic [NUM_CORES-1:0]           core_mask,
   input  logic [NUM_CORES*NUM_LANES-1:0] core_halt,
   input  logic [NUM_CORES-1:0]           core_error,
   input  logic                           mem_error,
`ifdef RUN_SUP_STALL_EN
   input  logic [NUM_CORES-1:0]           core_commit,
`endif
   output logic                           done,
   output logic [2:0]                     status,
   output logic [NUM_CORES-1:0]           halt_seen,
   output logic [NUM_CORES:0]             err_src,
   output logic [31:0]                    cycle_count
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [2:0] ST_PASS    = 3'd1;
   localparam logic [2:0] ST_TIMEOUT = 3'd2;
   localparam logic [2:0] ST_ERROR   = 3'd3;
   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

   state_t                 state_q, state_d;
   logic                   done_d;
   logic [2:0]             status_d;
   logic [NUM_CORES:0]     err_src_d;
   logic [31:0]            cyc_d, cyc_inc;
   logic [TIMEOUT_W-1:0]   wdog_q, wdog_d;
   logic [NUM_CORES-1:0]   mask_q, mask_d, seen_next;
   logic [DW-1:0]          drain_q, drain_d;
   logic                   clear, track, err_any, pass, expire;

   assign clear   = (state_q == S_IDLE) && start;
   assign track   = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign err_any = (|core_error) || mem_error;
   assign pass    = (mask_q != '0) && ((seen_next & mask_q) == mask_q);
   assign expire  = (wdog_q == TIMEOUT_W'(1));
   assign cyc_inc = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;

   for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
      run_supervisor_core #(.NUM_LANES(NUM_LANES)) u_core (
         .clk       (clk),
         .rst_n     (rst_n),
         .clear     (clear),
         .track     (track),
         .halt      (core_halt[c*NUM_LANES +: NUM_LANES]),
         .seen      (halt_seen[c]),
         .seen_next (seen_next[c])
      );
   end

`ifdef RUN_SUP_STALL_EN
   localparam logic [2:0] ST_STALL = 3'd4;
   logic [NUM_CORES-1:0] stall_hit;
   logic                 stall;

   for (genvar c = 0; c < NUM_CORES; c++) begin : g_stall
      run_supervisor_stall #(.STALL_LIMIT(STALL_LIMIT)) u_stall (
         .clk       (clk),
         .rst_n     (rst_n),
         .clear     (clear),
         .run       (state_q == S_RUN),
         .commit    (core_commit[c]),
         .seen_next (seen_next[c]),
         .mask_bit  (mask_q[c]),
         .stall_hit (stall_hit[c])
      );
   end
   assign stall = |stall_hit;
`endif

   always_comb begin
      state_d   = state_q;
      done_d    = done;
      status_d  = status;
      err_src_d = err_src;
      cyc_d     = cycle_count;
      wdog_d    = wdog_q;
      mask_d    = mask_q;
      drain_d   = drain_q;
      case (state_q)
         S_IDLE: if (start) begin
            state_d   = S_RUN;
            wdog_d    = timeout_cycles;
            mask_d    = core_mask;
            err_src_d = '0;
            cyc_d     = '0;
         end
         S_RUN: begin
            cyc_d = cyc_inc;
            if (wdog_q != '0) wdog_d = wdog_q - TIMEOUT_W'(1);
            // Priority within one edge: error, pass, stall, timeout.
            if (err_any) begin
               state_d   = S_DRAIN;
               err_src_d = {mem_error, core_error};
               drain_d   = DRAIN_LOAD;
            end else if (pass) begin
               state_d  = S_DONE;
               done_d   = 1'b1;
               status_d = ST_PASS;
`ifdef RUN_SUP_STALL_EN
            end else if (stall) begin
               state_d  = S_DONE;
               done_d   = 1'b1;
               status_d = ST_STALL;
`endif
            end else if (expire) begin
               state_d  = S_DONE;
               done_d   = 1'b1;
               status_d = ST_TIMEOUT;
            end
         end
         S_DRAIN: begin
            cyc_d = cyc_inc;
            if (drain_q == '0) begin
               state_d  = S_DONE;
               done_d   = 1'b1;
               status_d = ST_ERROR;
            end else begin
               drain_d = drain_q - DW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         done        <= 1'b0;
         status      <= 3'd0;
         err_src     <= '0;
         cycle_count <= '0;
         wdog_q      <= '0;
         mask_q      <= '0;
         drain_q     <= '0;
      end else begin
         state_q     <= state_d;
         done        <= done_d;
         status      <= status_d;
         err_src     <= err_src_d;
         cycle_count <= cyc_d;
         wdog_q      <= wdog_d;
         mask_q      <= mask_d;
         drain_q     <= drain_d;
      end
   end
endmodule
